// File: rtl/cdb_arbiter_if.sv
// Bundles the FU result handshake and the registered CDB broadcast shared by the
// functional units (master side) and the CDB arbiter (slave side).
interface cdb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    // FU i hands over a result at a rising edge where fu_valid[i] & fu_ready[i];
    // fu_ready never depends on fu_valid, and the FU keeps valid/tag/data stable until accepted.
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [NUM_FU-1:0]        fu_done;

    modport master (
        output fu_valid, fu_tag, fu_data,
        input  fu_ready, cdb_valid, cdb_tag, cdb_data, fu_done
    );

    modport slave (
        input  fu_valid, fu_tag, fu_data,
        output fu_ready, cdb_valid, cdb_tag, cdb_data, fu_done
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding register per FU, round-robin pick of one held
// result per cycle onto a registered broadcast, plus a per-FU done pulse.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    input logic          flush,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] hold_v;
    logic [TAG_W-1:0]  hold_tag  [NUM_FU];
    logic [DATA_W-1:0] hold_data [NUM_FU];
    logic [PTR_W-1:0]  rr_ptr;

    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    scan_idx;
    logic              grant_any;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] zero_tag;
    logic [NUM_FU-1:0] accept;
    logic [PTR_W-1:0]  next_ptr;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [NUM_FU-1:0] fu_done_q;

    // Scan from rr_ptr upward with wrap; the first full holding register wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(NUM_FU))
                scan_idx = scan_idx - (PTR_W+1)'(NUM_FU);
            if (!grant_any && hold_v[scan_idx[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[PTR_W-1:0];
            end
        end
    end

    assign grant    = grant_any ? (NUM_FU'(1) << grant_idx) : '0;
    assign ready    = ~hold_v | grant;
    assign next_ptr = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        zero_tag = '0;
        for (int i = 0; i < NUM_FU; i++)
            zero_tag[i] = (bus.fu_tag[i*TAG_W +: TAG_W] == '0);
    end

    // A tag-0 result is illegal and is silently dropped rather than held.
    assign accept = bus.fu_valid & ready & ~zero_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_v      <= '0;
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            fu_done_q   <= '0;
        end else if (flush) begin
            hold_v      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            fu_done_q   <= '0;
        end else begin
            hold_v <= (hold_v & ~grant) | accept;
            if (grant_any) begin
                cdb_valid_q <= 1'b1;
                cdb_tag_q   <= hold_tag[grant_idx];
                cdb_data_q  <= hold_data[grant_idx];
                fu_done_q   <= grant;
                rr_ptr      <= next_ptr;
            end else begin
                cdb_valid_q <= 1'b0;
                cdb_tag_q   <= '0;
                cdb_data_q  <= '0;
                fu_done_q   <= '0;
            end
        end
    end

    // Payload only matters while hold_v is set, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                hold_tag[i]  <= bus.fu_tag[i*TAG_W +: TAG_W];
                hold_data[i] <= bus.fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.fu_ready  = ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.fu_done   = fu_done_q;

    tag_nonzero_a: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.fu_valid & zero_tag) == '0);
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, checked against a
// queue-based model of the holding registers and round-robin order.
module tb_cdb_arbiter;
    localparam int NUM_FU = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int EW     = 3 + TAG_W + DATA_W;
    localparam int SW     = TAG_W + DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   cyc = 0;
    bit   check_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pending FU results (tag,data) in issue order, and the expected broadcasts.
    logic [SW-1:0] src_q [NUM_FU][$];
    logic [EW-1:0] exp_q [$];
    int            stamp_q [$];

    // Model: what each holding register contains and where the round-robin search starts.
    bit            m_hv   [NUM_FU];
    logic [TAG_W-1:0]  m_tag  [NUM_FU];
    logic [DATA_W-1:0] m_data [NUM_FU];
    int            m_ptr = 0;

    task automatic step(input bit do_rst, input bit do_flush);
        logic [NUM_FU-1:0] fv, exp_rdy;
        logic [NUM_FU*TAG_W-1:0] ft;
        logic [NUM_FU*DATA_W-1:0] fd;
        logic [SW-1:0] item;
        logic [2:0] gi;
        int g;
        @(negedge clk);
        fv = '0; ft = '0; fd = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (do_rst) begin
                fv[i] = 1'b1;
                ft[i*TAG_W +: TAG_W] = TAG_W'(i + 1);
                fd[i*DATA_W +: DATA_W] = $urandom;
            end else if (src_q[i].size() > 0) begin
                item = src_q[i][0];
                fv[i] = 1'b1;
                ft[i*TAG_W +: TAG_W] = item[SW-1 -: TAG_W];
                fd[i*DATA_W +: DATA_W] = item[DATA_W-1:0];
            end
        end
        bus.fu_valid = fv;
        bus.fu_tag   = ft;
        bus.fu_data  = fd;
        rst_n = !do_rst;
        flush = do_flush;

        g = -1;
        for (int k = 0; k < NUM_FU; k++)
            if (g < 0 && m_hv[(m_ptr + k) % NUM_FU]) g = (m_ptr + k) % NUM_FU;
        for (int i = 0; i < NUM_FU; i++) exp_rdy[i] = !m_hv[i] || (g == i);

        if (check_en) begin
            total++;
            if (bus.fu_ready !== exp_rdy) begin
                bad++;
                $display("FAIL fu_ready cyc=%0d: got %b, required %b", cyc, bus.fu_ready, exp_rdy);
            end
        end

        if (do_rst) begin
            for (int i = 0; i < NUM_FU; i++) m_hv[i] = 1'b0;
            m_ptr = 0;
        end else begin
            if (do_flush) begin
                for (int i = 0; i < NUM_FU; i++) m_hv[i] = 1'b0;
            end else if (g >= 0) begin
                gi = 3'(g);
                exp_q.push_back({gi, m_tag[g], m_data[g]});
                stamp_q.push_back(cyc + 1);
                m_hv[g] = 1'b0;
                m_ptr = (g + 1) % NUM_FU;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (fv[i] && exp_rdy[i]) begin
                    item = src_q[i].pop_front();
                    if (!do_flush) begin
                        m_hv[i]   = 1'b1;
                        m_tag[i]  = item[SW-1 -: TAG_W];
                        m_data[i] = item[DATA_W-1:0];
                    end
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic push_src(input int fu, input int tag, input logic [DATA_W-1:0] data);
        src_q[fu].push_back({TAG_W'(tag), data});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    // Monitor: every cycle the CDB is either the next expected broadcast or all-zero.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [NUM_FU-1:0] od;
        int st;
        if (check_en) begin
            total++;
            if (bus.cdb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL cdb_extra cyc=%0d: got tag=%0d data=%h, required no broadcast",
                             cyc, bus.cdb_tag, bus.cdb_data);
                end else begin
                    e  = exp_q.pop_front();
                    st = stamp_q.pop_front();
                    od = '0;
                    od[e[EW-1 -: 3]] = 1'b1;
                    if (bus.cdb_tag !== e[SW-1 -: TAG_W] || bus.cdb_data !== e[DATA_W-1:0] ||
                        bus.fu_done !== od || cyc != st) begin
                        bad++;
                        $display("FAIL cdb_bcast cyc=%0d: got tag=%0d data=%h done=%b, required tag=%0d data=%h done=%b cyc=%0d",
                                 cyc, bus.cdb_tag, bus.cdb_data, bus.fu_done,
                                 e[SW-1 -: TAG_W], e[DATA_W-1:0], od, st);
                    end
                end
            end else if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== '0 ||
                         bus.cdb_data !== '0 || bus.fu_done !== '0) begin
                bad++;
                $display("FAIL cdb_idle cyc=%0d: got valid=%b tag=%0d data=%h done=%b, required all zero",
                         cyc, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.fu_done);
            end
        end
    end

    initial begin
        bit busy;
        bus.fu_valid = '0;
        bus.fu_tag   = '0;
        bus.fu_data  = '0;

        // Reset with every FU requesting.
        step(1'b1, 1'b0);
        check_en = 1'b1;
        step(1'b1, 1'b0);
        idle(1);

        // Single result from FU1.
        push_src(1, 3, 32'hDEAD_BEEF);
        idle(4);

        // Park the pointer at 0 via FU3, then full contention.
        push_src(3, 9, 32'h3333_0000);
        idle(4);
        for (int i = 0; i < NUM_FU; i++) push_src(i, 10 + i, 32'hC0DE_0000 + DATA_W'(i));
        idle(7);

        // FU2 streams three results back to back.
        push_src(2, 5, 32'h0000_0005);
        push_src(2, 6, 32'h0000_0006);
        push_src(2, 7, 32'h0000_0007);
        idle(6);

        // Pointer is now 3: FU3 must go before FU0.
        push_src(3, 12, 32'hAAAA_0003);
        push_src(0, 13, 32'hBBBB_0000);
        idle(5);

        // Flush while FU0/FU2 are held and FU1 is being accepted.
        push_src(0, 1, 32'h1111_0000);
        push_src(2, 2, 32'h2222_0000);
        step(1'b0, 1'b0);
        push_src(1, 4, 32'h4444_0000);
        step(1'b0, 1'b1);
        idle(3);

        // Random traffic with occasional flushes and one mid-run reset.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_FU; i++)
                if (src_q[i].size() < 2 && $urandom_range(0, 2) == 0)
                    push_src(i, int'($urandom_range(1, 15)), $urandom);
            if (n == 300) begin
                step(1'b1, 1'b0);
                step(1'b1, 1'b0);
            end else begin
                step(1'b0, $urandom_range(0, 24) == 0);
            end
        end

        // Drain within a bounded number of cycles.
        busy = 1'b1;
        for (int k = 0; k < 100 && busy; k++) begin
            step(1'b0, 1'b0);
            busy = (exp_q.size() != 0);
            for (int i = 0; i < NUM_FU; i++)
                if (src_q[i].size() != 0 || m_hv[i]) busy = 1'b1;
        end
        idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d broadcasts still outstanding, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
